// File: rtl/riscv_mem_pipe.sv
// Memory stage: ALU pass-through, or a single aligned dmem load/store with lane steering and load extension.
// Latency 1 (ALU/misaligned), 2+ (store), 3+ (load); ex_mem_ack only when idle or when the held result retires.
module riscv_mem_pipe #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_mem_rdy,
    output logic              ex_mem_ack,
    input  logic [1:0]        ex_mem_op,
    input  logic [1:0]        ex_mem_size,
    input  logic              ex_mem_signed,
    input  logic [ADDR_W-1:0] ex_mem_addr,
    input  logic [XLEN-1:0]   ex_mem_wdata,
    input  logic [XLEN-1:0]   ex_mem_result,
    input  logic [4:0]        ex_mem_rd,
    output logic              dmem_rdy,
    input  logic              dmem_ack,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic              dmem_we,
    output logic [3:0]        dmem_be,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_resp_vld,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              mem_wb_rdy,
    input  logic              mem_wb_ack,
    output logic [XLEN-1:0]   mem_wb_data,
    output logic [4:0]        mem_wb_rd,
    output logic              mem_wb_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

    state_t state, state_nxt;

    logic [1:0]        size_q;
    logic              signed_q;
    logic              store_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   wb_data_q;
    logic [4:0]        wb_rd_q;
    logic              wb_err_q;

    logic              accept;
    logic              in_mem;
    logic              in_misal;
    logic [XLEN-1:0]   rdata_b;
    logic [XLEN-1:0]   rdata_h;
    logic [XLEN-1:0]   load_ext;

    assign ex_mem_ack = (state == IDLE) | ((state == OUT) & mem_wb_ack);
    assign accept     = ex_mem_rdy & ex_mem_ack;
    assign in_mem     = (ex_mem_op == 2'b01) | (ex_mem_op == 2'b10);
    // size 11 is handled as a word everywhere
    assign in_misal   = ((ex_mem_size == 2'b01) & ex_mem_addr[0]) |
                        (ex_mem_size[1] & (ex_mem_addr[1:0] != 2'b00));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = (in_mem & ~in_misal) ? REQ : OUT;
            end
            REQ: begin
                if (dmem_ack) state_nxt = store_q ? OUT : WAIT;
            end
            WAIT: begin
                if (dmem_resp_vld) state_nxt = OUT;
            end
            OUT: begin
                if (accept)          state_nxt = (in_mem & ~in_misal) ? REQ : OUT;
                else if (mem_wb_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rdata_b  = dmem_rdata >> {addr_q[1:0], 3'b000};
        rdata_h  = dmem_rdata >> {addr_q[1], 4'b0000};
        load_ext = dmem_rdata;
        case (size_q)
            2'b00:   load_ext = {{(XLEN-8){signed_q & rdata_b[7]}}, rdata_b[7:0]};
            2'b01:   load_ext = {{(XLEN-16){signed_q & rdata_h[15]}}, rdata_h[15:0]};
            default: load_ext = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            size_q    <= '0;
            signed_q  <= 1'b0;
            store_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wb_data_q <= '0;
            wb_rd_q   <= '0;
            wb_err_q  <= 1'b0;
        end else if (accept) begin
            size_q    <= ex_mem_size;
            signed_q  <= ex_mem_signed;
            store_q   <= (ex_mem_op == 2'b10);
            addr_q    <= ex_mem_addr;
            wdata_q   <= ex_mem_wdata;
            wb_rd_q   <= ex_mem_rd;
            // memory ops start with data=0 so a store or misaligned access retires 0
            wb_data_q <= in_mem ? '0 : ex_mem_result;
            wb_err_q  <= in_mem & in_misal;
        end else if ((state == WAIT) && dmem_resp_vld) begin
            wb_data_q <= load_ext;
        end
    end

    always_comb begin
        dmem_rdy   = (state == REQ);
        dmem_addr  = '0;
        dmem_we    = 1'b0;
        dmem_be    = 4'b0000;
        dmem_wdata = '0;
        if (dmem_rdy) begin
            dmem_addr = {addr_q[ADDR_W-1:2], 2'b00};
            dmem_we   = store_q;
            dmem_be   = 4'b1111;
            if (store_q) begin
                case (size_q)
                    2'b00: begin
                        dmem_be    = 4'b0001 << addr_q[1:0];
                        dmem_wdata = {4{wdata_q[7:0]}};
                    end
                    2'b01: begin
                        dmem_be    = 4'b0011 << {addr_q[1], 1'b0};
                        dmem_wdata = {2{wdata_q[15:0]}};
                    end
                    default: dmem_wdata = wdata_q;
                endcase
            end
        end
    end

    assign mem_wb_rdy  = (state == OUT);
    assign mem_wb_data = wb_data_q;
    assign mem_wb_rd   = wb_rd_q;
    assign mem_wb_err  = wb_err_q;

endmodule

// File: tb/tb_riscv_mem_pipe.sv
// Bench for riscv_mem_pipe: vector table plus hand sequences, writeback results checked through a scoreboard queue.
module tb_riscv_mem_pipe;

    logic        clk;
    logic        rst;
    logic        ex_mem_rdy;
    logic        ex_mem_ack;
    logic [1:0]  ex_mem_op;
    logic [1:0]  ex_mem_size;
    logic        ex_mem_signed;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_mem_wdata;
    logic [31:0] ex_mem_result;
    logic [4:0]  ex_mem_rd;
    logic        dmem_rdy;
    logic        dmem_ack;
    logic [31:0] dmem_addr;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_resp_vld;
    logic [31:0] dmem_rdata;
    logic        mem_wb_rdy;
    logic        mem_wb_ack;
    logic [31:0] mem_wb_data;
    logic [4:0]  mem_wb_rd;
    logic        mem_wb_err;

    riscv_mem_pipe #(.ADDR_W(32), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .ex_mem_rdy(ex_mem_rdy), .ex_mem_ack(ex_mem_ack), .ex_mem_op(ex_mem_op),
        .ex_mem_size(ex_mem_size), .ex_mem_signed(ex_mem_signed), .ex_mem_addr(ex_mem_addr),
        .ex_mem_wdata(ex_mem_wdata), .ex_mem_result(ex_mem_result), .ex_mem_rd(ex_mem_rd),
        .dmem_rdy(dmem_rdy), .dmem_ack(dmem_ack), .dmem_addr(dmem_addr), .dmem_we(dmem_we),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_resp_vld(dmem_resp_vld),
        .dmem_rdata(dmem_rdata), .mem_wb_rdy(mem_wb_rdy), .mem_wb_ack(mem_wb_ack),
        .mem_wb_data(mem_wb_data), .mem_wb_rd(mem_wb_rd), .mem_wb_err(mem_wb_err)
    );

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] result;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          ack_d;
        int          resp_d;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_data;
        logic        e_err;
        int          e_lat;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        err;
        int          push_cyc;
        int          lat;
    } sb_t;

    sb_t         sb[$];
    vec_t        vt[$];
    int          checks, errors, cyc, req_cycles;
    int          ack_delay, resp_delay;
    logic [31:0] rdata_val, cur_addr, cur_wdata;
    logic [3:0]  cur_be;
    logic        cur_we;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [31:0] data, input logic [4:0] rd, input logic err, input int lat);
        sb_t s;
        s.data = data; s.rd = rd; s.err = err; s.push_cyc = cyc; s.lat = lat;
        sb.push_back(s);
    endtask

    // Writeback monitor: every retirement pops and compares the oldest expectation.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (mem_wb_rdy && mem_wb_ack) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wb_unexpected: got retire rd=%0d data=%h expected none", mem_wb_rd, mem_wb_data);
                end else begin
                    e = sb.pop_front();
                    chk("wb_data", mem_wb_data, e.data);
                    chk("wb_rd", 32'(mem_wb_rd), 32'(e.rd));
                    chk("wb_err", 32'(mem_wb_err), 32'(e.err));
                    if (e.lat > 0) chk("wb_latency", 32'(cyc - e.push_cyc), 32'(e.lat));
                end
            end
        end
    end

    // Data-memory model: acks after ack_delay stall cycles, answers loads resp_delay cycles after ack.
    initial begin
        int wait_cnt, resp_cnt;
        bit resp_pend, last_we;
        wait_cnt = 0; resp_cnt = 0; resp_pend = 0; last_we = 0;
        dmem_ack = 1'b0; dmem_resp_vld = 1'b0; dmem_rdata = 32'hBAD0BAD0;
        forever begin
            @(negedge clk);
            dmem_resp_vld = 1'b0;
            dmem_rdata    = 32'hBAD0BAD0;
            if (dmem_ack) begin
                dmem_ack = 1'b0;
                if (!last_we) begin
                    resp_pend = 1;
                    resp_cnt  = resp_delay;
                end
            end
            if (resp_pend) begin
                if (resp_cnt == 0) begin
                    dmem_resp_vld = 1'b1;
                    dmem_rdata    = rdata_val;
                    resp_pend     = 0;
                end else begin
                    resp_cnt--;
                end
            end
            if (dmem_rdy) begin
                req_cycles++;
                chk("dmem_addr", dmem_addr, cur_addr);
                chk("dmem_we", 32'(dmem_we), 32'(cur_we));
                chk("dmem_be", 32'(dmem_be), 32'(cur_be));
                if (cur_we) chk("dmem_wdata", dmem_wdata, cur_wdata);
                last_we = dmem_we;
                if (wait_cnt >= ack_delay) begin
                    dmem_ack = 1'b1;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted it, rdy still high.
    task automatic issue(input logic [1:0] op, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] result,
                         input logic [4:0] rd, input logic [31:0] e_data, input logic e_err, input int e_lat);
        int n;
        ex_mem_op = op; ex_mem_size = size; ex_mem_signed = sgn; ex_mem_addr = addr;
        ex_mem_wdata = wdata; ex_mem_result = result; ex_mem_rd = rd; ex_mem_rdy = 1'b1;
        push_exp(e_data, rd, e_err, e_lat);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ex_mem_ack && n < 100);
        chk("accept_seen", 32'(ex_mem_ack), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    task automatic set_mem(input vec_t v);
        cur_addr = v.e_addr; cur_we = v.e_we; cur_be = v.e_be; cur_wdata = v.e_wdata;
        ack_delay = v.ack_d; resp_delay = v.resp_d; rdata_val = v.rdata; req_cycles = 0;
    endtask

    task automatic run_vec(input vec_t v);
        set_mem(v);
        issue(v.op, v.size, v.sgn, v.addr, v.wdata, v.result, v.rd, v.e_data, v.e_err, v.e_lat);
        ex_mem_rdy = 1'b0;
        drain();
        chk($sformatf("req_cycles_rd%0d", v.rd), 32'(req_cycles), v.e_req ? 32'(v.ack_d + 1) : 32'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mkv(input logic [1:0] op, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] result,
                                 input logic [4:0] rd, input logic [31:0] rdata, input int ack_d, input int resp_d,
                                 input logic e_req, input logic [31:0] e_addr, input logic e_we,
                                 input logic [3:0] e_be, input logic [31:0] e_wdata,
                                 input logic [31:0] e_data, input logic e_err, input int e_lat);
        vec_t v;
        v.op = op; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata; v.result = result;
        v.rd = rd; v.rdata = rdata; v.ack_d = ack_d; v.resp_d = resp_d; v.e_req = e_req;
        v.e_addr = e_addr; v.e_we = e_we; v.e_be = e_be; v.e_wdata = e_wdata;
        v.e_data = e_data; v.e_err = e_err; v.e_lat = e_lat;
        return v;
    endfunction

    initial begin
        int   c0, c1, wb_seen;
        vec_t rv;
        checks = 0; errors = 0; req_cycles = 0;
        ack_delay = 0; resp_delay = 0; rdata_val = 0;
        cur_addr = 0; cur_wdata = 0; cur_be = 0; cur_we = 0;
        rst = 1'b1; ex_mem_rdy = 1'b0; ex_mem_op = 2'b00; ex_mem_size = 2'b00; ex_mem_signed = 1'b0;
        ex_mem_addr = 0; ex_mem_wdata = 0; ex_mem_result = 0; ex_mem_rd = 0; mem_wb_ack = 1'b1;

        //                op     size   sgn   addr          wdata         result        rd      rdata         ack rsp req  e_addr        we    be       e_wdata       e_data        err   lat
        vt.push_back(mkv(2'd0, 2'd2, 1'b0, 32'h0000_0000, 32'h0,        32'hDEADBEEF, 5'd5,  32'h0,        0, 0, 1'b0, 32'h0,        1'b0, 4'h0,    32'h0,        32'hDEADBEEF, 1'b0, 1));
        vt.push_back(mkv(2'd1, 2'd0, 1'b1, 32'h0000_1003, 32'h0,        32'h0,        5'd7,  32'h80123456, 0, 0, 1'b1, 32'h0000_1000, 1'b0, 4'hF,  32'h0,        32'hFFFFFF80, 1'b0, 3));
        vt.push_back(mkv(2'd1, 2'd0, 1'b0, 32'h0000_1003, 32'h0,        32'h0,        5'd8,  32'h80123456, 0, 0, 1'b1, 32'h0000_1000, 1'b0, 4'hF,  32'h0,        32'h00000080, 1'b0, 3));
        vt.push_back(mkv(2'd2, 2'd1, 1'b0, 32'h0000_2002, 32'h0000ABCD, 32'h0,        5'd9,  32'h0,        3, 0, 1'b1, 32'h0000_2000, 1'b1, 4'b1100, 32'hABCDABCD, 32'h0,       1'b0, 5));
        vt.push_back(mkv(2'd1, 2'd2, 1'b0, 32'h0000_3001, 32'h0,        32'h0,        5'd10, 32'h0,        0, 0, 1'b0, 32'h0,        1'b0, 4'h0,    32'h0,        32'h0,        1'b1, 1));
        vt.push_back(mkv(2'd1, 2'd1, 1'b1, 32'h0000_1002, 32'h0,        32'h0,        5'd11, 32'h80123456, 0, 2, 1'b1, 32'h0000_1000, 1'b0, 4'hF,  32'h0,        32'hFFFF8012, 1'b0, 5));
        vt.push_back(mkv(2'd1, 2'd1, 1'b0, 32'h0000_1000, 32'h0,        32'h0,        5'd12, 32'h1234F00D, 1, 0, 1'b1, 32'h0000_1000, 1'b0, 4'hF,  32'h0,        32'h0000F00D, 1'b0, 4));
        vt.push_back(mkv(2'd1, 2'd1, 1'b1, 32'h0000_1000, 32'h0,        32'h0,        5'd13, 32'h1234F00D, 0, 0, 1'b1, 32'h0000_1000, 1'b0, 4'hF,  32'h0,        32'hFFFFF00D, 1'b0, 3));
        vt.push_back(mkv(2'd2, 2'd0, 1'b0, 32'h0000_4001, 32'h000000A5, 32'h0,        5'd14, 32'h0,        0, 0, 1'b1, 32'h0000_4000, 1'b1, 4'b0010, 32'hA5A5A5A5, 32'h0,       1'b0, 2));
        vt.push_back(mkv(2'd2, 2'd2, 1'b0, 32'h0000_4008, 32'h12345678, 32'h0,        5'd15, 32'h0,        1, 0, 1'b1, 32'h0000_4008, 1'b1, 4'hF,  32'h12345678, 32'h0,        1'b0, 3));
        vt.push_back(mkv(2'd1, 2'd0, 1'b0, 32'h0000_5001, 32'h0,        32'h0,        5'd16, 32'h11223344, 0, 0, 1'b1, 32'h0000_5000, 1'b0, 4'hF,  32'h0,        32'h00000033, 1'b0, 3));
        vt.push_back(mkv(2'd2, 2'd1, 1'b0, 32'h0000_6003, 32'h0000FFFF, 32'h0,        5'd17, 32'h0,        0, 0, 1'b0, 32'h0,        1'b0, 4'h0,    32'h0,        32'h0,        1'b1, 1));
        vt.push_back(mkv(2'd3, 2'd0, 1'b0, 32'h0000_0001, 32'h0,        32'h55AA55AA, 5'd31, 32'h0,        0, 0, 1'b0, 32'h0,        1'b0, 4'h0,    32'h0,        32'h55AA55AA, 1'b0, 1));
        vt.push_back(mkv(2'd1, 2'd3, 1'b1, 32'h0000_7004, 32'h0,        32'h0,        5'd18, 32'hCAFEF00D, 0, 1, 1'b1, 32'h0000_7004, 1'b0, 4'hF,  32'h0,        32'hCAFEF00D, 1'b0, 4));
        vt.push_back(mkv(2'd1, 2'd3, 1'b0, 32'h0000_7002, 32'h0,        32'h0,        5'd19, 32'h0,        0, 0, 1'b0, 32'h0,        1'b0, 4'h0,    32'h0,        32'h0,        1'b1, 1));
        vt.push_back(mkv(2'd1, 2'd0, 1'b1, 32'h0000_1000, 32'h0,        32'h0,        5'd20, 32'h0000007F, 0, 0, 1'b1, 32'h0000_1000, 1'b0, 4'hF,  32'h0,        32'h0000007F, 1'b0, 3));
        vt.push_back(mkv(2'd2, 2'd0, 1'b0, 32'h0000_4003, 32'h123456EE, 32'h0,        5'd21, 32'h0,        0, 0, 1'b1, 32'h0000_4000, 1'b1, 4'b1000, 32'hEEEEEEEE, 32'h0,       1'b0, 2));
        vt.push_back(mkv(2'd0, 2'd2, 1'b0, 32'h0000_0003, 32'h0,        32'h0BADF00D, 5'd22, 32'h0,        0, 0, 1'b0, 32'h0,        1'b0, 4'h0,    32'h0,        32'h0BADF00D, 1'b0, 1));

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ex_ack", 32'(ex_mem_ack), 32'd1);
        chk("reset_dmem_rdy", 32'(dmem_rdy), 32'd0);
        chk("reset_dmem_we", 32'(dmem_we), 32'd0);
        chk("reset_dmem_be", 32'(dmem_be), 32'd0);
        chk("reset_wb_rdy", 32'(mem_wb_rdy), 32'd0);
        chk("reset_wb_data", mem_wb_data, 32'd0);
        chk("reset_wb_rd", 32'(mem_wb_rd), 32'd0);
        chk("reset_wb_err", 32'(mem_wb_err), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < vt.size(); i++) run_vec(vt[i]);

        // Ten back-to-back ALU ops must each take exactly one cycle to be accepted.
        c0 = cyc;
        for (int i = 0; i < 10; i++)
            issue(2'd0, 2'd2, 1'b0, 32'h0, 32'h0, 32'h1000 + 32'(i), 5'(i + 1), 32'h1000 + 32'(i), 1'b0, 1);
        c1 = cyc;
        ex_mem_rdy = 1'b0;
        chk("alu_throughput_cycles", 32'(c1 - c0), 32'd10);
        drain();
        @(posedge clk);
        #1;

        // Writeback stall: next instruction waits, held result stays put, accept coincides with mem_wb_ack.
        mem_wb_ack = 1'b0;
        issue(2'd0, 2'd0, 1'b0, 32'h0, 32'h0, 32'hA5A50001, 5'd3, 32'hA5A50001, 1'b0, 0);
        ex_mem_result = 32'h5A5A0002;
        ex_mem_rd = 5'd4;
        push_exp(32'h5A5A0002, 5'd4, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_ex_ack", 32'(ex_mem_ack), 32'd0);
            chk("bp_wb_rdy", 32'(mem_wb_rdy), 32'd1);
            chk("bp_wb_data", mem_wb_data, 32'hA5A50001);
            chk("bp_wb_rd", 32'(mem_wb_rd), 32'd3);
            @(posedge clk);
            #1;
        end
        mem_wb_ack = 1'b1;
        #1 chk("bp_ack_rise", 32'(ex_mem_ack), 32'd1);
        @(posedge clk);
        #1 ex_mem_rdy = 1'b0;
        @(negedge clk);
        chk("bp_next_wb_rdy", 32'(mem_wb_rdy), 32'd1);
        chk("bp_next_wb_data", mem_wb_data, 32'h5A5A0002);
        drain();
        @(posedge clk);
        #1;

        // Reset while waiting for load data: the instruction is dropped and the late response ignored.
        rv = mkv(2'd1, 2'd0, 1'b1, 32'h0000_1003, 32'h0, 32'h0, 5'd6, 32'h80123456, 0, 5,
                 1'b1, 32'h0000_1000, 1'b0, 4'hF, 32'h0, 32'hFFFFFF80, 1'b0, 3);
        set_mem(rv);
        issue(rv.op, rv.size, rv.sgn, rv.addr, rv.wdata, rv.result, rv.rd, rv.e_data, rv.e_err, 0);
        ex_mem_rdy = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("rst_wait_dmem_rdy", 32'(dmem_rdy), 32'd0);
        chk("rst_wait_wb_rdy", 32'(mem_wb_rdy), 32'd0);
        chk("rst_wait_ex_ack", 32'(ex_mem_ack), 32'd1);
        wb_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_wb_rdy) wb_seen++;
        end
        chk("late_resp_ignored", 32'(wb_seen), 32'd0);
        @(posedge clk);
        #1;
        rv.resp_d = 0;
        run_vec(rv);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
